// File: rtl/magcomp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
package magcomp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result codes, bit order {gt, eq, lt}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

  function automatic int idx_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/magcomp_bitcell.sv
// One-bit compare cell: flags a difference and which operand wins at that bit.
module magcomp_bitcell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic is_msb,
  input  logic signed_mode,
  output logic differ,
  output logic a_wins
);

  // At a two's-complement sign bit, a set bit means the smaller value.
  assign differ = a_bit ^ b_bit;
  assign a_wins = differ & (a_bit ^ (is_msb & signed_mode));

endmodule

// File: rtl/magcomp_serial.sv
// Bit-serial MSB-first magnitude comparator with start/busy/done handshake.
module magcomp_serial
  import magcomp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int IDXW = idx_width(WIDTH);
  localparam logic [IDXW-1:0] IDX_MSB = IDXW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sm_reg;
  logic [IDXW-1:0]  idx_reg;
  logic             found_reg;
  logic             pend_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [2:0]       res_reg;

  logic differ;
  logic a_wins;

  magcomp_bitcell u_cell (
    .a_bit      (a_reg[idx_reg]),
    .b_bit      (b_reg[idx_reg]),
    .is_msb     (idx_reg == IDX_MSB),
    .signed_mode(sm_reg),
    .differ     (differ),
    .a_wins     (a_wins)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sm_reg    <= 1'b0;
      idx_reg   <= '0;
      found_reg <= 1'b0;
      pend_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      res_reg   <= RES_NONE;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            sm_reg    <= signed_mode;
            idx_reg   <= IDX_MSB;
            found_reg <= 1'b0;
            pend_reg  <= 1'b0;
            res_reg   <= RES_NONE;
            busy_reg  <= 1'b1;
            state_reg <= SCAN;
          end else begin
            state_reg <= IDLE;
          end
        end
        SCAN: begin
          if (differ && !found_reg && EARLY_EXIT != 0) begin
            res_reg   <= a_wins ? RES_GT : RES_LT;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else if (idx_reg == '0) begin
            // Last bit: the first recorded difference wins over this one.
            if (found_reg)
              res_reg <= pend_reg ? RES_GT : RES_LT;
            else if (differ)
              res_reg <= a_wins ? RES_GT : RES_LT;
            else
              res_reg <= RES_EQ;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            if (differ && !found_reg) begin
              found_reg <= 1'b1;
              pend_reg  <= a_wins;
            end
            idx_reg <= idx_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign gt   = res_reg[2];
  assign eq   = res_reg[1];
  assign lt   = res_reg[0];

endmodule

// File: tb/tb_magcomp_serial.sv
// Self-checking bench: three comparator configurations run side by side.
module tb_magcomp_serial;

  localparam logic [2:0] R_GT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;
  localparam logic [2:0] R_NO = 3'b000;

  logic       clk = 1'b0;
  logic       rst, start, smode;
  logic [7:0] a, b;
  logic [3:0] a4, b4;
  logic [2:0] busy_v, done_v, gt_v, eq_v, lt_v;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [2:0] exp_res [3];
  int         exp_lat [3];

  typedef struct {
    logic [7:0] a, b;
    logic [3:0] a4, b4;
    logic       sm;
    logic [2:0] r0, r1, r2;
    int         l0, l1, l2;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  // index 0: WIDTH=8 early exit, 1: WIDTH=8 fixed latency, 2: WIDTH=4 early exit
  magcomp_serial #(.WIDTH(8), .EARLY_EXIT(1)) u_e8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .signed_mode(smode),
    .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0]));
  magcomp_serial #(.WIDTH(8), .EARLY_EXIT(0)) u_f8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .signed_mode(smode),
    .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1]));
  magcomp_serial #(.WIDTH(4), .EARLY_EXIT(1)) u_e4 (
    .clk(clk), .rst(rst), .start(start), .a(a4), .b(b4), .signed_mode(smode),
    .busy(busy_v[2]), .done(done_v[2]), .gt(gt_v[2]), .eq(eq_v[2]), .lt(lt_v[2]));

  function automatic logic [2:0] flags(input int i);
    return {gt_v[i], eq_v[i], lt_v[i]};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: numeric comparison of the operand values; latency from the
  // position of the most significant differing bit.
  function automatic void model(input int w, input bit ee, input logic [7:0] av,
                                input logic [7:0] bv, input bit sm,
                                output logic [2:0] res, output int lat);
    longint mask, ua, ub, va, vb, x;
    int p;
    mask = (longint'(1) << w) - 1;
    ua = longint'(av) & mask;
    ub = longint'(bv) & mask;
    va = ua;
    vb = ub;
    if (sm && ua[w-1]) va = va - (longint'(1) << w);
    if (sm && ub[w-1]) vb = vb - (longint'(1) << w);
    res = (va > vb) ? R_GT : (va < vb) ? R_LT : R_EQ;
    x = ua ^ ub;
    if (x == 0 || !ee) lat = w;
    else begin
      p = 0;
      for (int i = 0; i < w; i++) if (x[i]) p = i;
      lat = w - p;
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Launch one compare on all three instances and check latency, flags,
  // busy/done behaviour and flag hold against exp_res/exp_lat.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input logic [3:0] a4v, input logic [3:0] b4v, input logic sm);
    int seen [3];
    int lat [3];
    int ndone [3];
    int bad [3];
    logic [2:0] got [3];
    a = av; b = bv; a4 = a4v; b4 = b4v; smode = sm; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
    smode = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      seen[i] = 0; lat[i] = -1; ndone[i] = 0; got[i] = R_NO;
      bad[i] = (busy_v[i] !== 1'b1 || done_v[i] !== 1'b0 || flags(i) !== R_NO) ? 1 : 0;
    end
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (done_v[i] === 1'b1) ndone[i]++;
        if (!seen[i] && done_v[i] === 1'b1) begin
          seen[i] = 1; lat[i] = k; got[i] = flags(i);
          if (busy_v[i] !== 1'b0) bad[i]++;
        end else if (!seen[i]) begin
          if (busy_v[i] !== 1'b1 || flags(i) !== R_NO) bad[i]++;
        end else begin
          if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || flags(i) !== got[i]) bad[i]++;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      $display("op a=%02h b=%02h a4=%h b4=%h sm=%0d inst%0d: res=%03b lat=%0d",
               av, bv, a4v, b4v, sm, i, got[i], lat[i]);
      chk($sformatf("lat%0d", i), lat[i], exp_lat[i]);
      chk($sformatf("res%0d", i), got[i], exp_res[i]);
      chk($sformatf("ndone%0d", i), ndone[i], 1);
      chk($sformatf("handshake%0d", i), bad[i], 0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_res[0] = v.r0; exp_res[1] = v.r1; exp_res[2] = v.r2;
    exp_lat[0] = v.l0; exp_lat[1] = v.l1; exp_lat[2] = v.l2;
    run_op(v.a, v.b, v.a4, v.b4, v.sm);
  endtask

  task automatic wait_done(input int i, input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      #1;
      if (done_v[i] === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, ndone, r;
    logic [7:0] ra, rb;
    logic [3:0] ra4, rb4;
    logic rsm;

    tbl[0] = '{8'hA5, 8'hA5, 4'h5, 4'h5, 1'b0, R_EQ, R_EQ, R_EQ, 8, 8, 4};
    tbl[1] = '{8'h80, 8'h7F, 4'h8, 4'h7, 1'b0, R_GT, R_GT, R_GT, 1, 8, 1};
    tbl[2] = '{8'h80, 8'h7F, 4'h8, 4'h7, 1'b1, R_LT, R_LT, R_LT, 1, 8, 1};
    tbl[3] = '{8'h12, 8'h13, 4'hF, 4'h1, 1'b1, R_LT, R_LT, R_LT, 8, 8, 1};
    tbl[4] = '{8'h80, 8'h00, 4'h8, 4'h8, 1'b0, R_GT, R_GT, R_EQ, 1, 8, 4};
    tbl[5] = '{8'h80, 8'h00, 4'h8, 4'h8, 1'b1, R_LT, R_LT, R_EQ, 1, 8, 4};
    tbl[6] = '{8'h01, 8'h02, 4'h2, 4'h1, 1'b0, R_LT, R_LT, R_GT, 7, 8, 3};
    tbl[7] = '{8'hFF, 8'h00, 4'h0, 4'hF, 1'b1, R_LT, R_LT, R_GT, 1, 8, 1};

    a = '0; b = '0; a4 = '0; b4 = '0; smode = 1'b0; start = 1'b0; rst = 1'b1;
    do_reset();
    chk("reset_busy", busy_v, 3'b000);
    chk("reset_done", done_v, 3'b000);
    chk("reset_flags", {gt_v, eq_v, lt_v}, 9'd0);

    for (int t = 0; t < 8; t++) run_vec(tbl[t]);

    for (int t = 0; t < 30; t++) begin
      ra = 8'($urandom);
      r = int'($urandom_range(0, 3));
      if (r == 0) rb = ra;
      else if (r == 1) rb = ra ^ (8'h01 << $urandom_range(0, 7));
      else rb = 8'($urandom);
      ra4 = 4'($urandom);
      rb4 = (r == 0) ? ra4 : 4'($urandom);
      rsm = 1'($urandom);
      model(8, 1'b1, ra, rb, rsm, exp_res[0], exp_lat[0]);
      model(8, 1'b0, ra, rb, rsm, exp_res[1], exp_lat[1]);
      model(4, 1'b1, {4'h0, ra4}, {4'h0, rb4}, rsm, exp_res[2], exp_lat[2]);
      run_op(ra, rb, ra4, rb4, rsm);
    end

    // start during SCAN is ignored; start in the DONE cycle is accepted
    do_reset();
    a = 8'h01; b = 8'h02; smode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; a = 8'hFF; b = 8'h00;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, 10, lat);
    $display("ignored-start seq: lat=%0d flags=%03b", lat, flags(0));
    chk("ign_lat", lat, 4);
    chk("ign_res", flags(0), R_LT);
    start = 1'b1; a = 8'hFF; b = 8'h00; smode = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    $display("back-to-back accept: busy=%0d flags=%03b", busy_v[0], flags(0));
    chk("b2b_busy", busy_v[0], 1'b1);
    chk("b2b_clear", flags(0), R_NO);
    wait_done(0, 10, lat);
    $display("back-to-back seq: lat=%0d flags=%03b", lat, flags(0));
    chk("b2b_lat", lat, 1);
    chk("b2b_res", flags(0), R_GT);

    // reset in the third SCAN cycle aborts with no done pulse
    do_reset();
    a = 8'hA5; b = 8'hA5; a4 = 4'h5; b4 = 4'h5; smode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    $display("abort: busy=%03b done=%03b", busy_v, done_v);
    chk("abort_busy", busy_v, 3'b000);
    chk("abort_done", done_v, 3'b000);
    chk("abort_flags", {gt_v, eq_v, lt_v}, 9'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1 if (done_v !== 3'b000) ndone++;
    end
    chk("abort_nodone", ndone, 0);
    run_vec(tbl[1]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/magcomp_serial.md
Name: magcomp_serial

Overview:
- Parametrised, bit-serial, MSB-first magnitude comparator for two WIDTH-bit operands.
- Supports unsigned or two's-complement comparison, selected per operation.
- Uses a start/busy/done handshake and can optionally finish early at the first differing bit.
- Used wherever a wide compare is needed and area matters more than latency. Produces one-hot greater/equal/less flags.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..64.
- EARLY_EXIT, 1, 1 = finish at the first differing bit; 0 = always scan all WIDTH bits (fixed latency).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled on the rising edge of clk.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- signed_mode  input  1  1 = two's-complement compare; captured when start is accepted.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse: result is valid.
- gt  output  1  A > B.
- eq  output  1  A == B.
- lt  output  1  A < B.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; busy, done, gt, eq, lt all 0; internal operand registers and bit index cleared. rst has priority over all other inputs.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start=1 is accepted: capture a, b and signed_mode; set idx=WIDTH-1; clear gt/eq/lt; go to SCAN.
- SCAN (busy=1): each cycle examines bit idx of the captured operands.
  - Bits differ, unsigned: a[idx]=1 gives gt, otherwise lt.
  - Bits differ at idx=WIDTH-1 with signed_mode=1: the sense is inverted (a[MSB]=1 means A is negative, so lt).
  - Once a difference is recorded, later bits never change the result.
  - EARLY_EXIT=1 and bits differ: go to DONE.
  - idx=0 and no difference seen: set eq; go to DONE.
  - EARLY_EXIT=0: a difference is latched and scanning continues to idx=0.
  - Otherwise idx decrements by 1.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back compares, no dead cycle).
- Result flags:
  - gt/eq/lt are registered and one-hot once valid; they are valid from the done cycle.
  - They hold until the next accepted start, which clears them to 000.
  - 000 means "no result".
- Latency: start is sampled at edge E0; done is high in the cycle after edge E_n.
  - EARLY_EXIT=0, or operands equal: n=WIDTH.
  - EARLY_EXIT=1: n = (number of equal leading MSBs) + 1.
- Boundary conditions:
  - start while in SCAN: ignored; no effect on operands or result.
  - a, b, signed_mode changing after acceptance: no effect.
  - rst during SCAN or DONE: aborts; outputs return to reset values next cycle; no done pulse.
  - eq is independent of signed_mode.
  - Index width is $clog2(WIDTH). The index never wraps; it stops at 0.

Decomposition:
- Package magcomp_pkg holds:
  - the state enum typedef (IDLE, SCAN, DONE);
  - result-code localparams RES_NONE=3'b000, RES_GT=3'b100, RES_EQ=3'b010, RES_LT=3'b001, with bit order {gt,eq,lt};
  - a helper function for idx width.
- Optional sub-module magcomp_bitcell: combinational, one bit.
  - Inputs: a_bit, b_bit, is_msb, signed_mode.
  - Outputs: differ, a_wins.
  - The FSM and shift/index logic stay in the top module.

Test Plan (WIDTH=8 unless stated):
- a=0xA5, b=0xA5, unsigned, EARLY_EXIT=1 -> busy for 8 cycles; done in cycle 8; {gt,eq,lt}=010; flags held until next start.
- a=0x80, b=0x7F: unsigned -> done in cycle 1 with gt=1. Repeat with signed_mode=1 -> lt=1, same latency.
- a=0x12, b=0x13, EARLY_EXIT=1 -> lt=1, done in cycle 8. Repeat with EARLY_EXIT=0 and a=0x80, b=0x00 -> gt=1, done in cycle 8 (fixed latency).
- Start a=0x01, b=0x02; pulse start with a=0xFF, b=0x00 during SCAN -> ignored; result lt=1; then start asserted in the DONE cycle -> accepted, flags clear to 000, next result gt=1.
- rst=1 in the third SCAN cycle -> next cycle busy=done=gt=eq=lt=0, state IDLE; no done pulse afterwards; a new start works normally.
- Signed, WIDTH=4: a=4'hF (-1), b=4'h1 -> lt=1; a=4'h8 (-8), b=4'h8 -> eq=1 after 4 cycles.
